// File: rtl/fault_mon_pkg.sv
// Shared types and defaults for the multi-channel fault monitor.
// Optional sticky-severity feature is enabled with the FAULT_MON_STICKY_EN macro.
package fault_mon_pkg;

    // Baseline capture first, then continuous monitoring against the captured means.
    typedef enum logic {
        ST_BASELINE = 1'b0,
        ST_MONITOR  = 1'b1
    } state_e;

    // Severity 0 (no fault) .. 4 (worst).
    typedef logic [2:0] sev_t;

    localparam sev_t SEV_NONE = 3'd0;

    // Default severity thresholds on |mean - baseline|, strictly ascending.
    localparam int THR1_DEF = 10;
    localparam int THR2_DEF = 25;
    localparam int THR3_DEF = 50;
    localparam int THR4_DEF = 100;

    // Larger of two severities.
    function automatic sev_t sev_max(input sev_t a, input sev_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fault_mon_sev.sv
// Combinational severity classifier: |mean - base| against four thresholds.
module fault_mon_sev
    import fault_mon_pkg::*;
#(
    parameter int DW   = 8,
    parameter int THR1 = THR1_DEF,
    parameter int THR2 = THR2_DEF,
    parameter int THR3 = THR3_DEF,
    parameter int THR4 = THR4_DEF
) (
    input  logic [DW-1:0] mean_i,
    input  logic [DW-1:0] base_i,
    output logic [2:0]    sev_o
);

    logic [DW-1:0] diff;
    logic [31:0]   diff_w;

    // Absolute difference without a sign bit: subtract the smaller from the larger.
    always_comb begin
        diff = (mean_i >= base_i) ? (mean_i - base_i) : (base_i - mean_i);
    end

    assign diff_w = 32'(diff);

    // Highest threshold reached wins.
    always_comb begin
        sev_o = SEV_NONE;
        if      (diff_w >= 32'(THR4)) sev_o = 3'd4;
        else if (diff_w >= 32'(THR3)) sev_o = 3'd3;
        else if (diff_w >= 32'(THR2)) sev_o = 3'd2;
        else if (diff_w >= 32'(THR1)) sev_o = 3'd1;
    end

endmodule

// File: rtl/fault_monitor_mc.sv
// Multi-channel windowed-mean fault monitor.
// Each channel averages 2^LOG2_DEPTH samples; the first window per channel becomes
// its baseline, later windows are graded against it by fault_mon_sev.
// Define FAULT_MON_STICKY_EN to add the clr input and fault_any/fault_max outputs,
// which remember the worst severity seen per channel.
module fault_monitor_mc
    import fault_mon_pkg::*;
#(
    parameter int CH         = 4,
    parameter int DW         = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int THR1       = THR1_DEF,
    parameter int THR2       = THR2_DEF,
    parameter int THR3       = THR3_DEF,
    parameter int THR4       = THR4_DEF,
    localparam int CHW       = $clog2(CH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  in_data,
    input  logic           rebase,
`ifdef FAULT_MON_STICKY_EN
    input  logic           clr,
    output logic           fault_any,
    output logic [2:0]     fault_max,
`endif
    output logic           base_ready,
    output logic           win_done,
    output logic           fault_valid,
    output logic [2:0]     fault_sev,
    output logic [CHW-1:0] fault_ch
);

    localparam int N  = 1 << LOG2_DEPTH;
    localparam int SW = DW + LOG2_DEPTH;   // holds N full-scale samples
    localparam int CW = LOG2_DEPTH + 1;

    state_e                  state_q, state_d;
    logic [CH-1:0][SW-1:0]   sum_q, sum_d;
    logic [CH-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [CH-1:0]           done_q, done_d;
    logic [CH-1:0][DW-1:0]   base_q, base_d;

    logic [CH-1:0]           hit;    // valid sample addressed to this channel
    logic [CH-1:0]           take;   // sample actually accumulated
    logic [CH-1:0]           fin;    // sample closes this channel's window
    logic [SW-1:0]           sel_sum;
    logic [SW-1:0]           acc_sum;
    logic [DW-1:0]           sel_base;
    logic [DW-1:0]           mean;
    sev_t                    sev;
    logic                    fire;

    logic                    win_done_q, win_done_d;
    sev_t                    fault_sev_q, fault_sev_d;
    logic [CHW-1:0]          fault_ch_q, fault_ch_d;

    // Channel decode; an out-of-range index matches no channel and is dropped.
    always_comb begin
        hit      = '0;
        take     = '0;
        fin      = '0;
        sel_sum  = '0;
        sel_base = '0;
        for (int i = 0; i < CH; i++) begin
            hit[i]  = in_valid && !rebase && (in_ch == CHW'(i));
            take[i] = hit[i] && !((state_q == ST_BASELINE) && done_q[i]);
            fin[i]  = take[i] && (cnt_q[i] == CW'(N - 1));
            if (hit[i]) begin
                sel_sum  = sum_q[i];
                sel_base = base_q[i];
            end
        end
    end

    assign acc_sum = sel_sum + SW'(in_data);
    assign mean    = DW'(acc_sum >> LOG2_DEPTH);
    assign fire    = (state_q == ST_MONITOR) && (|fin);

    fault_mon_sev #(
        .DW   (DW),
        .THR1 (THR1),
        .THR2 (THR2),
        .THR3 (THR3),
        .THR4 (THR4)
    ) u_sev (
        .mean_i (mean),
        .base_i (sel_base),
        .sev_o  (sev)
    );

    // Per-channel accumulation, window close and baseline capture.
    always_comb begin
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        base_d = base_q;
        if (rebase) begin
            sum_d  = '0;
            cnt_d  = '0;
            done_d = '0;
            base_d = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (fin[i]) begin
                    sum_d[i] = '0;
                    cnt_d[i] = '0;
                    if (state_q == ST_BASELINE) begin
                        base_d[i] = mean;
                        done_d[i] = 1'b1;
                    end
                end else if (take[i]) begin
                    sum_d[i] = acc_sum;
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Window datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            done_q <= '0;
            base_q <= '0;
        end else begin
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            base_q <= base_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_BASELINE;
        else       state_q <= state_d;
    end

    // FSM next state: leave BASELINE as soon as the last baseline lands.
    always_comb begin
        state_d = state_q;
        if (rebase)
            state_d = ST_BASELINE;
        else if ((state_q == ST_BASELINE) && (&done_d))
            state_d = ST_MONITOR;
    end

    // Report registers: pulse on a monitor completion, hold severity/channel otherwise.
    always_comb begin
        win_done_d  = fire;
        fault_sev_d = fault_sev_q;
        fault_ch_d  = fault_ch_q;
        if (fire) begin
            fault_sev_d = sev;
            fault_ch_d  = in_ch;
        end
    end

    // Report register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_done_q  <= 1'b0;
            fault_sev_q <= SEV_NONE;
            fault_ch_q  <= '0;
        end else begin
            win_done_q  <= win_done_d;
            fault_sev_q <= fault_sev_d;
            fault_ch_q  <= fault_ch_d;
        end
    end

    // FSM / report outputs.
    always_comb begin
        base_ready  = (state_q == ST_MONITOR);
        win_done    = win_done_q;
        fault_valid = win_done_q && (fault_sev_q != SEV_NONE);
        fault_sev   = fault_sev_q;
        fault_ch    = fault_ch_q;
    end

`ifdef FAULT_MON_STICKY_EN
    logic [CH-1:0][2:0] smax_q, smax_d;
    sev_t               smax_all;

    // Worst severity per channel; clearing wins over a same-cycle update.
    always_comb begin
        smax_d = smax_q;
        if (clr || rebase) begin
            smax_d = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (fire && fin[i] && (sev > smax_q[i]))
                    smax_d[i] = sev;
            end
        end
    end

    // Sticky severity registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) smax_q <= '0;
        else       smax_q <= smax_d;
    end

    // Reduce to the worst severity over all channels.
    always_comb begin
        smax_all = SEV_NONE;
        for (int i = 0; i < CH; i++)
            smax_all = sev_max(smax_all, smax_q[i]);
    end

    assign fault_max = smax_all;
    assign fault_any = (smax_all != SEV_NONE);
`endif

endmodule

// File: tb/tb_fault_monitor_mc.sv
// Self-checking bench for fault_monitor_mc: directed scenarios plus random traffic
// compared against a queue-based window/baseline model. A second 3-channel
// instance checks that out-of-range channel indices are ignored.
module tb_fault_monitor_mc;

    localparam int CH = 4;
    localparam int N  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_ch = '0;
    logic [7:0] in_data = '0;
    logic       rebase = 1'b0;
    logic       clr = 1'b0;
    logic       base_ready, win_done, fault_valid;
    logic [2:0] fault_sev;
    logic [1:0] fault_ch;

    logic       v3 = 1'b0;
    logic [1:0] ch3 = '0;
    logic [7:0] d3 = '0;
    logic       r3, w3, fv3;
    logic [2:0] s3;
    logic [1:0] c3;

`ifdef FAULT_MON_STICKY_EN
    logic       fault_any, any3;
    logic [2:0] fault_max, max3;
`endif

    always #5 clk = ~clk;

    fault_monitor_mc #(.CH(4), .DW(8), .LOG2_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .rebase      (rebase),
`ifdef FAULT_MON_STICKY_EN
        .clr         (clr),
        .fault_any   (fault_any),
        .fault_max   (fault_max),
`endif
        .base_ready  (base_ready),
        .win_done    (win_done),
        .fault_valid (fault_valid),
        .fault_sev   (fault_sev),
        .fault_ch    (fault_ch)
    );

    fault_monitor_mc #(.CH(3), .DW(8), .LOG2_DEPTH(2)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (v3),
        .in_ch       (ch3),
        .in_data     (d3),
        .rebase      (1'b0),
`ifdef FAULT_MON_STICKY_EN
        .clr         (1'b0),
        .fault_any   (any3),
        .fault_max   (max3),
`endif
        .base_ready  (r3),
        .win_done    (w3),
        .fault_valid (fv3),
        .fault_sev   (s3),
        .fault_ch    (c3)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: raw samples of the open window per channel.
    int q[CH][$];
    int base[CH];
    bit bdone[CH];
    bit mon;
    bit e_win;
    int e_sev, e_ch;
    int smax[CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sev_of(input int diff);
        if (diff >= 100) return 4;
        if (diff >= 50)  return 3;
        if (diff >= 25)  return 2;
        if (diff >= 10)  return 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            q[c].delete();
            base[c]  = 0;
            bdone[c] = 1'b0;
        end
        mon = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        e_win = 1'b0;
        e_sev = 0;
        e_ch  = 0;
        for (int c = 0; c < CH; c++) smax[c] = 0;
    endtask

    task automatic model(input bit v, input int ch, input int d, input bit rb, input bit cl);
        int s, m, diff, sv;
        bit all;
        e_win = 1'b0;
        if (rb || cl) for (int c = 0; c < CH; c++) smax[c] = 0;
        if (rb) begin
            model_clear();
            return;
        end
        if (!v || ch >= CH) return;
        if (!mon && bdone[ch]) return;
        q[ch].push_back(d);
        if (q[ch].size() == N) begin
            s = 0;
            for (int k = 0; k < N; k++) s += q[ch][k];
            m = s / N;
            q[ch].delete();
            if (!mon) begin
                base[ch]  = m;
                bdone[ch] = 1'b1;
                all = 1'b1;
                for (int c = 0; c < CH; c++) if (!bdone[c]) all = 1'b0;
                if (all) mon = 1'b1;
            end else begin
                diff  = (m > base[ch]) ? m - base[ch] : base[ch] - m;
                sv    = sev_of(diff);
                e_win = 1'b1;
                e_sev = sv;
                e_ch  = ch;
                if (!cl && sv > smax[ch]) smax[ch] = sv;
            end
        end
    endtask

    task automatic check_outs();
        chk("base_ready",  base_ready,  mon);
        chk("win_done",    win_done,    e_win);
        chk("fault_valid", fault_valid, (e_win && e_sev != 0));
        chk("fault_sev",   fault_sev,   e_sev);
        chk("fault_ch",    fault_ch,    e_ch);
`ifdef FAULT_MON_STICKY_EN
        begin
            int mx = 0;
            for (int c = 0; c < CH; c++) if (smax[c] > mx) mx = smax[c];
            chk("fault_max", fault_max, mx);
            chk("fault_any", fault_any, (mx != 0));
        end
`endif
    endtask

    // One clock of stimulus; outputs checked on the following falling edge.
    task automatic step(input bit v, input int ch, input int d, input bit rb);
        in_valid = v;
        in_ch    = 2'(ch);
        in_data  = 8'(d);
        rebase   = rb;
        @(posedge clk);
        model(v, ch, d, rb, clr);
        @(negedge clk);
        check_outs();
        clr    = 1'b0;
        rebase = 1'b0;
    endtask

    task automatic win4(input int ch, input int a, input int b, input int c, input int d);
        step(1, ch, a, 0);
        step(1, ch, b, 0);
        step(1, ch, c, 0);
        step(1, ch, d, 0);
    endtask

    task automatic baseline40();
        for (int s = 0; s < N; s++)
            for (int c = 0; c < CH; c++)
                step(1, c, 40, 0);
    endtask

    task automatic step3(input bit v, input int ch, input int d, input bit ew, input bit er);
        v3  = v;
        ch3 = 2'(ch);
        d3  = 8'(d);
        @(posedge clk);
        @(negedge clk);
        chk("ch3_win_done",   w3, ew);
        chk("ch3_base_ready", r3, er);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_base_ready",  base_ready,  0);
        chk("rst_win_done",    win_done,    0);
        chk("rst_fault_valid", fault_valid, 0);
        chk("rst_fault_sev",   fault_sev,   0);
        chk("rst_fault_ch",    fault_ch,    0);
        chk("rst3_base_ready", r3,          0);
        reset = 1'b0;

        // Baseline of 40 everywhere; ready after the 16th sample, no pulses before.
        baseline40();
        chk("ready_after_16", base_ready, 1);

        // Small deviation on ch2: window completes without a fault.
        win4(2, 40, 40, 40, 52);
        chk("ch2_win", win_done, 1);
        chk("ch2_fv", fault_valid, 0);
        chk("ch2_sev", fault_sev, 0);
        chk("ch2_ch", fault_ch, 2);
        step(0, 0, 0, 0);
        chk("ch2_hold_ch", fault_ch, 2);

        // Large deviation on ch1.
        win4(1, 200, 200, 200, 200);
        chk("ch1_fv", fault_valid, 1);
        chk("ch1_sev", fault_sev, 4);
        chk("ch1_ch", fault_ch, 1);
        step(0, 0, 0, 0);
        chk("ch1_pulse_end", fault_valid, 0);
        chk("ch1_hold_sev", fault_sev, 4);

        // Threshold boundaries on ch0 (base 40).
        win4(0, 50, 50, 50, 50);   chk("b_diff10", fault_sev, 1);
        win4(0, 49, 49, 49, 49);   chk("b_diff9", fault_sev, 0);
        win4(0, 49, 50, 50, 50);   chk("b_trunc", fault_sev, 0);
        win4(0, 65, 65, 65, 65);   chk("b_diff25", fault_sev, 2);
        win4(0, 64, 64, 64, 64);   chk("b_diff24", fault_sev, 1);
        win4(0, 90, 90, 90, 90);   chk("b_diff50", fault_sev, 3);
        win4(0, 139, 139, 139, 139); chk("b_diff99", fault_sev, 3);
        win4(0, 0, 0, 0, 0);       chk("b_below", fault_sev, 2);
        win4(0, 140, 140, 140, 140); chk("b_diff100", fault_sev, 4);

        // Reset in the middle of a window clears immediately and discards partials.
        step(1, 0, 200, 0);
        step(1, 0, 200, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("mid_rst_ready", base_ready, 0);
        chk("mid_rst_sev", fault_sev, 0);
        chk("mid_rst_ch", fault_ch, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        baseline40();
        win4(0, 40, 40, 40, 40);
        chk("post_rst_sev", fault_sev, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit v, rb;
            int ch, d;
            v  = ($urandom_range(0, 9) < 7);
            ch = $urandom_range(0, 3);
            d  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(25, 60);
            rb = ($urandom_range(0, 99) == 0);
            step(v, ch, d, rb);
        end

        // Rebase mid-window drops back to BASELINE with no pulse.
        step(0, 0, 0, 1);
        baseline40();
        step(1, 3, 200, 0);
        step(1, 3, 200, 0);
        step(1, 3, 200, 1);
        chk("rb_no_pulse", win_done, 0);
        chk("rb_not_ready", base_ready, 0);
        win4(1, 200, 200, 200, 200);
        chk("rb_base_no_pulse", win_done, 0);
        for (int s = 0; s < N; s++) begin
            step(1, 0, 40, 0);
            step(1, 2, 40, 0);
            step(1, 3, 40, 0);
        end
        chk("rb_ready_again", base_ready, 1);
        win4(1, 200, 200, 200, 200);
        chk("rb_new_base_sev", fault_sev, 0);
        // Rebase on the closing sample suppresses the completion.
        step(1, 1, 10, 0);
        step(1, 1, 10, 0);
        step(1, 1, 10, 0);
        step(1, 1, 10, 1);
        chk("rb_last_no_pulse", win_done, 0);

`ifdef FAULT_MON_STICKY_EN
        baseline40();
        win4(0, 65, 65, 65, 65);
        win4(1, 200, 200, 200, 200);
        win4(2, 50, 50, 50, 50);
        chk("st_max", fault_max, 4);
        chk("st_any", fault_any, 1);
        clr = 1'b1;
        step(0, 0, 0, 0);
        chk("st_clr_max", fault_max, 0);
        chk("st_clr_any", fault_any, 0);
        step(1, 3, 200, 0);
        step(1, 3, 200, 0);
        step(1, 3, 200, 0);
        clr = 1'b1;
        step(1, 3, 200, 0);
        chk("st_clr_wins", fault_max, 0);
`endif

        // 3-channel instance: index 3 is out of range and must not disturb anything.
        step(0, 0, 0, 0);
        for (int s = 0; s < N; s++) begin
            for (int c = 0; c < 3; c++)
                step3(1, c, 40, 0, (s == N - 1 && c == 2));
            step3(1, 3, 255, 0, (s == N - 1));
        end
        step3(1, 0, 40, 0, 1);
        step3(1, 3, 255, 0, 1);
        step3(1, 0, 40, 0, 1);
        step3(1, 0, 40, 0, 1);
        step3(1, 0, 40, 1, 1);
        chk("ch3_sev", s3, 0);
        chk("ch3_ch", c3, 0);
        for (int k = 0; k < N; k++) step3(1, 3, 255, 0, 1);
        step3(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
